topk_insert_sorter: RTL and testbench
=====================================

# topk_insert_sorter

Streaming top-K selector that consumes one (value, index) pair per cycle and maintains a sorted list of the K best entries. Where the parallel MIN/MAX primitive reduces PORT lanes to a single extremum, this block works the other way: serial in, parallel out, producing a K-wide sorted result word. It sits after the distance unit in the KNN path and emits the neighbour list for one query per transaction.

## Interface
- DATA_WIDTH, 16, width of each compared value (unsigned)
- IDX_WIDTH, 16, width of the index carried with each value
- K, 8, list depth (K >= 1)
- MINMAX, 0, 0: keep K smallest, ascending; 1: keep K largest, descending

Clock and reset: one clock; reset is synchronous and active-high.

- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  clear list and begin a new query
- in_vld  in  1  input element valid
- in_rdy  out  1  block can accept an element
- in_data  in  DATA_WIDTH  element value
- in_idx  in  IDX_WIDTH  element index
- in_last  in  1  marks the final element of the query
- out_vld  out  1  sorted list valid
- out_rdy  in  1  consumer accepts the list
- out_data  out  DATA_WIDTH*K  sorted values; slot 0 in bits [DATA_WIDTH-1:0] is the best
- out_idx  out  IDX_WIDTH*K  indices matching out_data slots
- out_cnt  out  $clog2(K+1)  number of valid slots, saturates at K

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_rdy=0, out_vld=0. If start=1, clear all slots (data=0, idx=0, valid=0, out_cnt=0) and go to RUN.
- RUN: in_rdy=1. A handshake (in_vld & in_rdy) inserts the element into the list in the same cycle.
  - Insertion rule: an invalid slot counts as worse than any value. The new element goes into the first slot i whose entry it strictly beats (`<` for MINMAX=0, `>` for MINMAX=1). Slots i..K-2 shift down by one, and slot K-1 is discarded.
  - If it beats no valid slot and out_cnt<K, it goes into slot out_cnt. Otherwise it is dropped.
  - Ties: the existing entry stays ahead, so the earliest arrival wins (matches the strict compare of the MIN/MAX primitive).
  - out_cnt increments on each insert until it reaches K.
  - A handshake with in_last=1 moves the state to DONE.
  - start=1 in RUN restarts: the list is cleared, any same-cycle element is discarded, and the state stays in RUN. start has priority over the handshake.
- DONE: in_rdy=0, out_vld=1, and out_data/out_idx/out_cnt are held stable. When out_rdy=1, go to IDLE and drop out_vld. start is ignored in DONE.
- Slots at or beyond out_cnt read as data=0, idx=0.
- All comparisons are unsigned, full DATA_WIDTH, with no arithmetic widening.

## Timing
- Reset values: state=IDLE, in_rdy=0, out_vld=0, out_cnt=0, all out_data/out_idx=0.
- rst=1 in any state aborts the query and forces the reset values on the next edge, including mid-RUN and while out_vld is high.
- Throughput is one element per cycle in RUN. There are no bubbles between elements.
- An element accepted at edge t is reflected in out_data/out_idx/out_cnt after edge t. in_last accepted at edge t gives out_vld=1 in cycle t+1.
- Minimum transaction for a single element with in_last: start at t0, element at t1, out_vld from t2.
- in_rdy and out_vld are registered state decodes with no combinational path from in_vld or out_rdy.
- A single element with in_last is legal. An empty query (no elements) is not supported; the upstream block always sends at least one element.

## Structure
- Shared package sort_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the MINMAX encoding constants SORT_MIN=0 and SORT_MAX=1, shared with the MIN/MAX primitive users.
- One natural sub-module, topk_slot: a single list entry holding data, idx and valid. Its inputs are the new element, the previous slot's contents and the previous slot's "beaten" flag. Its outputs are its own contents and its own "beaten" flag.
- The top level instantiates K topk_slot instances in a chain, plus the FSM and out_cnt.

## Test plan
- K=4, MINMAX=0, stream (9,0),(3,1),(7,2),(1,3),(5,4,last) → out_data={1,3,5,7}, out_idx={3,1,4,2}, out_cnt=4, out_vld in the cycle after last.
- K=4, MINMAX=1, same stream → out_data={9,7,5,3}, out_idx={0,2,4,1}.
- K=4, MINMAX=0, stream (4,0),(4,1),(2,2),(4,3,last) → out_data={2,4,4,4}, out_idx={2,0,1,3} (tie stability).
- K=8, 3 elements (6,0),(2,1),(0xFFFF,2,last) → out_cnt=3, out_data slots 0..2={2,6,0xFFFF}, slots 3..7=0.
- Backpressure and restart:
  - hold out_rdy=0 for 5 cycles in DONE → outputs stable and in_rdy=0; then out_rdy=1 → IDLE next cycle;
  - start asserted mid-RUN after 2 elements → list cleared, out_cnt=0.
- rst pulsed mid-RUN with in_vld=1 → next cycle all outputs at reset values. A later start plus (5,7,last) gives out_data slot 0=5, idx=7, out_cnt=1.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the sorting blocks in the KNN path.
//   sort_state_e : top-K sorter control states (IDLE, RUN, DONE)
//   SORT_MIN/MAX : MINMAX encoding, also used by the MIN/MAX primitive
//   cnt_width()  : width of a counter that must hold 0..k
package sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sort_state_e;

  localparam int unsigned SORT_MIN = 0;
  localparam int unsigned SORT_MAX = 1;

  function automatic int unsigned cnt_width(input int unsigned k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/topk_insert_sorter_if.sv
// Handshake bundle of the top-K insertion sorter.
//   start                        : clear list, begin a new query
//   in_vld/in_rdy                : element handshake carrying in_data, in_idx, in_last
//   out_vld/out_rdy              : result handshake carrying out_data, out_idx, out_cnt
// Modports: master drives elements and accepts results, slave is the sorter.
interface topk_insert_sorter_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = 16,
  parameter int unsigned K          = 8
);

  localparam int unsigned CntW = sort_pkg::cnt_width(K);

  logic                      start;
  logic                      in_vld;
  logic                      in_rdy;
  logic [DATA_WIDTH-1:0]     in_data;
  logic [IDX_WIDTH-1:0]      in_idx;
  logic                      in_last;
  logic                      out_vld;
  logic                      out_rdy;
  logic [DATA_WIDTH*K-1:0]   out_data;
  logic [IDX_WIDTH*K-1:0]    out_idx;
  logic [CntW-1:0]           out_cnt;

  modport master (
    output start, in_vld, in_data, in_idx, in_last, out_rdy,
    input  in_rdy, out_vld, out_data, out_idx, out_cnt
  );

  modport slave (
    input  start, in_vld, in_data, in_idx, in_last, out_rdy,
    output in_rdy, out_vld, out_data, out_idx, out_cnt
  );

endinterface

// File: rtl/topk_slot.sv
// One entry of the top-K list.
//   clk, rst                : clock, synchronous active-high reset
//   clr                     : clear entry (new query)
//   ins                     : an element is being inserted this cycle
//   new_data/new_idx        : the element being inserted
//   prev_data/idx/vld       : contents of the slot one position better
//   prev_beaten             : the new element beats the better slot
//   data/idx/vld            : this slot's contents (zero while invalid)
//   beaten                  : the new element beats this slot
// Because the list is sorted and valid slots form a prefix, "beaten" is
// monotonic along the chain: the first beaten slot takes the new element and
// every slot after it takes its predecessor.
module topk_slot
  import sort_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = 16,
  parameter int unsigned MINMAX     = SORT_MIN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  ins,
  input  logic [DATA_WIDTH-1:0] new_data,
  input  logic [IDX_WIDTH-1:0]  new_idx,
  input  logic [DATA_WIDTH-1:0] prev_data,
  input  logic [IDX_WIDTH-1:0]  prev_idx,
  input  logic                  prev_vld,
  input  logic                  prev_beaten,
  output logic [DATA_WIDTH-1:0] data,
  output logic [IDX_WIDTH-1:0]  idx,
  output logic                  vld,
  output logic                  beaten
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic                  vld_q, vld_d;
  logic                  better;

  // Strict compare: an equal value never displaces the earlier arrival.
  always_comb begin
    if (MINMAX == SORT_MAX) begin
      better = new_data > data_q;
    end else begin
      better = new_data < data_q;
    end
  end

  // An empty slot is worse than any value.
  assign beaten = !vld_q || better;

  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    if (clr) begin
      data_d = '0;
      idx_d  = '0;
      vld_d  = 1'b0;
    end else if (ins && prev_beaten) begin
      data_d = prev_data;
      idx_d  = prev_idx;
      vld_d  = prev_vld;
    end else if (ins && beaten) begin
      data_d = new_data;
      idx_d  = new_idx;
      vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      idx_q  <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      idx_q  <= idx_d;
      vld_q  <= vld_d;
    end
  end

  assign data = data_q;
  assign idx  = idx_q;
  assign vld  = vld_q;

endmodule

// File: rtl/topk_insert_sorter.sv
// Streaming top-K selector: accepts one (value, index) per cycle and keeps
// the K best entries sorted, slot 0 best. Emits the list once per query.
//   clk, rst : clock, synchronous active-high reset
//   bus      : topk_insert_sorter_if slave (start, element in, list out)
// MINMAX = SORT_MIN keeps the K smallest ascending, SORT_MAX the K largest
// descending. in_rdy/out_vld are pure state decodes.
module topk_insert_sorter
  import sort_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IDX_WIDTH  = 16,
  parameter int unsigned K          = 8,
  parameter int unsigned MINMAX     = SORT_MIN
) (
  input  logic                 clk,
  input  logic                 rst,
  topk_insert_sorter_if.slave  bus
);

  localparam int unsigned CntW = cnt_width(K);

  sort_state_e     state_q, state_d;
  logic            clr;
  logic            ins;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] slot_data   [K];
  logic [IDX_WIDTH-1:0]  slot_idx    [K];
  logic                  slot_vld    [K];
  logic                  slot_beaten [K];
  logic [DATA_WIDTH-1:0] prev_data   [K];
  logic [IDX_WIDTH-1:0]  prev_idx    [K];
  logic                  prev_vld    [K];
  logic                  prev_beaten [K];

  // start wins over a same-cycle element in RUN; DONE ignores start.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    ins     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clr     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.start) begin
          clr = 1'b1;
        end else if (bus.in_vld) begin
          ins = 1'b1;
          if (bus.in_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (bus.out_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The last slot is beaten whenever the element lands anywhere in the list.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ins && slot_beaten[K-1] && (cnt_q != CntW'(K))) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar i = 0; i < K; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign prev_data[i]   = '0;
      assign prev_idx[i]    = '0;
      assign prev_vld[i]    = 1'b0;
      assign prev_beaten[i] = 1'b0;
    end else begin : g_link
      assign prev_data[i]   = slot_data[i-1];
      assign prev_idx[i]    = slot_idx[i-1];
      assign prev_vld[i]    = slot_vld[i-1];
      assign prev_beaten[i] = slot_beaten[i-1];
    end

    topk_slot #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_WIDTH  (IDX_WIDTH),
      .MINMAX     (MINMAX)
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .ins         (ins),
      .new_data    (bus.in_data),
      .new_idx     (bus.in_idx),
      .prev_data   (prev_data[i]),
      .prev_idx    (prev_idx[i]),
      .prev_vld    (prev_vld[i]),
      .prev_beaten (prev_beaten[i]),
      .data        (slot_data[i]),
      .idx         (slot_idx[i]),
      .vld         (slot_vld[i]),
      .beaten      (slot_beaten[i])
    );

    assign bus.out_data[i*DATA_WIDTH +: DATA_WIDTH] = slot_data[i];
    assign bus.out_idx[i*IDX_WIDTH +: IDX_WIDTH]    = slot_idx[i];
  end

  assign bus.in_rdy  = (state_q == RUN);
  assign bus.out_vld = (state_q == DONE);
  assign bus.out_cnt = cnt_q;

endmodule

// File: tb/tb_topk_insert_sorter.sv
// Bench for topk_insert_sorter: three instances (K=4 min, K=4 max, K=8 min)
// share one stimulus stream. The reference keeps every accepted element of
// the current query and derives the expected list by stable selection.
module tb_topk_insert_sorter;
  import sort_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_vld;
  logic        in_last;
  logic        out_rdy;
  logic [15:0] in_data;
  logic [15:0] in_idx;

  always #5 clk = ~clk;

  topk_insert_sorter_if #(.DATA_WIDTH(16), .IDX_WIDTH(16), .K(4)) b0 ();
  topk_insert_sorter_if #(.DATA_WIDTH(16), .IDX_WIDTH(16), .K(4)) b1 ();
  topk_insert_sorter_if #(.DATA_WIDTH(16), .IDX_WIDTH(16), .K(8)) b2 ();

  assign b0.start = start;   assign b1.start = start;   assign b2.start = start;
  assign b0.in_vld = in_vld; assign b1.in_vld = in_vld; assign b2.in_vld = in_vld;
  assign b0.in_data = in_data; assign b1.in_data = in_data; assign b2.in_data = in_data;
  assign b0.in_idx = in_idx; assign b1.in_idx = in_idx; assign b2.in_idx = in_idx;
  assign b0.in_last = in_last; assign b1.in_last = in_last; assign b2.in_last = in_last;
  assign b0.out_rdy = out_rdy; assign b1.out_rdy = out_rdy; assign b2.out_rdy = out_rdy;

  topk_insert_sorter #(.DATA_WIDTH(16), .IDX_WIDTH(16), .K(4), .MINMAX(SORT_MIN)) u_k4min (
    .clk (clk), .rst (rst), .bus (b0)
  );
  topk_insert_sorter #(.DATA_WIDTH(16), .IDX_WIDTH(16), .K(4), .MINMAX(SORT_MAX)) u_k4max (
    .clk (clk), .rst (rst), .bus (b1)
  );
  topk_insert_sorter #(.DATA_WIDTH(16), .IDX_WIDTH(16), .K(8), .MINMAX(SORT_MIN)) u_k8min (
    .clk (clk), .rst (rst), .bus (b2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int st       = 0;  // 0 idle, 1 collecting, 2 result offered
  int q_data[$];
  int q_idx[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected top-kk of the elements accepted so far; on equal values the
  // earlier arrival is preferred.
  function automatic void model(input int kk, input int mm, output logic [255:0] ed,
                                output logic [255:0] ei, output int ec);
    bit taken [256];
    int best;
    ed = '0;
    ei = '0;
    ec = 0;
    for (int j = 0; j < 256; j++) taken[j] = 1'b0;
    for (int s = 0; s < kk; s++) begin
      best = -1;
      for (int j = 0; j < q_data.size(); j++) begin
        if (!taken[j]) begin
          if (best < 0) best = j;
          else if (mm == 1 && q_data[j] > q_data[best]) best = j;
          else if (mm == 0 && q_data[j] < q_data[best]) best = j;
        end
      end
      if (best < 0) break;
      taken[best] = 1'b1;
      ed[s*16 +: 16] = 16'(q_data[best]);
      ei[s*16 +: 16] = 16'(q_idx[best]);
      ec++;
    end
  endfunction

  task automatic check_all(input string tag);
    logic [255:0] ed, ei;
    int ec;
    model(4, 0, ed, ei, ec);
    chk({tag, "/k4min_data"}, b0.out_data, ed);
    chk({tag, "/k4min_idx"}, b0.out_idx, ei);
    chk({tag, "/k4min_cnt"}, b0.out_cnt, 256'(ec));
    chk({tag, "/k4min_rdy"}, b0.in_rdy, 256'(st == 1));
    chk({tag, "/k4min_vld"}, b0.out_vld, 256'(st == 2));
    model(4, 1, ed, ei, ec);
    chk({tag, "/k4max_data"}, b1.out_data, ed);
    chk({tag, "/k4max_idx"}, b1.out_idx, ei);
    chk({tag, "/k4max_cnt"}, b1.out_cnt, 256'(ec));
    chk({tag, "/k4max_vld"}, b1.out_vld, 256'(st == 2));
    model(8, 0, ed, ei, ec);
    chk({tag, "/k8min_data"}, b2.out_data, ed);
    chk({tag, "/k8min_idx"}, b2.out_idx, ei);
    chk({tag, "/k8min_cnt"}, b2.out_cnt, 256'(ec));
    chk({tag, "/k8min_rdy"}, b2.in_rdy, 256'(st == 1));
  endtask

  // Advance the reference by the current inputs, clock once, then check.
  task automatic step(input string tag);
    if (rst) begin
      st = 0;
      q_data.delete();
      q_idx.delete();
    end else if (st == 0) begin
      if (start) begin
        st = 1;
        q_data.delete();
        q_idx.delete();
      end
    end else if (st == 1) begin
      if (start) begin
        q_data.delete();
        q_idx.delete();
      end else if (in_vld) begin
        q_data.push_back(int'(in_data));
        q_idx.push_back(int'(in_idx));
        if (in_last) st = 2;
      end
    end else begin
      if (out_rdy) st = 0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic feed(input int d, input int i, input bit last, input string tag);
    in_vld  = 1'b1;
    in_data = 16'(d);
    in_idx  = 16'(i);
    in_last = last;
    step(tag);
    in_vld  = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic begin_query(input string tag);
    start = 1'b1;
    step(tag);
    start = 1'b0;
  endtask

  task automatic release_result(input string tag);
    out_rdy = 1'b1;
    step(tag);
    out_rdy = 1'b0;
  endtask

  initial begin
    int len;
    int v;
    rst = 1'b1; start = 1'b0; in_vld = 1'b0; in_last = 1'b0; out_rdy = 1'b0;
    in_data = '0; in_idx = '0;
    step("reset");
    step("reset_hold");
    rst = 1'b0;
    step("idle");

    // Basic query, both orderings
    begin_query("q1_start");
    feed(9, 0, 0, "q1_e0");
    feed(3, 1, 0, "q1_e1");
    feed(7, 2, 0, "q1_e2");
    feed(1, 3, 0, "q1_e3");
    feed(5, 4, 1, "q1_e4");
    chk("q1_min_data", b0.out_data, 64'h0007_0005_0003_0001);
    chk("q1_min_idx", b0.out_idx, 64'h0002_0004_0001_0003);
    chk("q1_min_cnt", b0.out_cnt, 4);
    chk("q1_min_vld", b0.out_vld, 1);
    chk("q1_max_data", b1.out_data, 64'h0003_0005_0007_0009);
    chk("q1_max_idx", b1.out_idx, 64'h0001_0004_0002_0000);

    // Backpressure: held result, start and stray elements ignored
    for (int c = 0; c < 5; c++) begin
      start  = (c == 2);
      in_vld = (c == 3);
      in_data = 16'h0000;
      step("q1_hold");
    end
    start = 1'b0;
    in_vld = 1'b0;
    chk("q1_hold_data", b0.out_data, 64'h0007_0005_0003_0001);
    release_result("q1_release");
    chk("q1_idle_vld", b0.out_vld, 0);

    // Tie stability
    begin_query("q2_start");
    feed(4, 0, 0, "q2_e0");
    feed(4, 1, 0, "q2_e1");
    feed(2, 2, 0, "q2_e2");
    feed(4, 3, 1, "q2_e3");
    chk("q2_tie_data", b0.out_data, 64'h0004_0004_0004_0002);
    chk("q2_tie_idx", b0.out_idx, 64'h0003_0001_0000_0002);
    release_result("q2_release");

    // Partial list in K=8, extreme value
    begin_query("q3_start");
    feed(6, 0, 0, "q3_e0");
    feed(2, 1, 0, "q3_e1");
    feed(16'hFFFF, 2, 1, "q3_e2");
    chk("q3_k8_cnt", b2.out_cnt, 3);
    chk("q3_k8_data", b2.out_data, 128'h0000_0000_0000_0000_0000_FFFF_0006_0002);
    chk("q3_k8_idx", b2.out_idx, 128'h0000_0000_0000_0000_0000_0002_0000_0001);
    release_result("q3_release");

    // Restart mid-query; the same-cycle element is discarded
    begin_query("q4_start");
    feed(8, 0, 0, "q4_e0");
    feed(1, 1, 0, "q4_e1");
    start = 1'b1;
    feed(3, 2, 0, "q4_restart");
    start = 1'b0;
    chk("q4_restart_cnt", b0.out_cnt, 0);
    chk("q4_restart_data", b2.out_data, 0);
    chk("q4_restart_rdy", b0.in_rdy, 1);
    feed(2, 5, 1, "q4_e2");
    release_result("q4_release");

    // Random queries with gaps, narrow value range to provoke ties
    for (int q = 0; q < 20; q++) begin
      begin_query("rnd_start");
      len = $urandom_range(1, 12);
      for (int e = 0; e < len; e++) begin
        if ($urandom_range(0, 3) == 0) begin
          in_data = 16'($urandom);
          step("rnd_gap");
        end
        v = (q % 2 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 65535);
        feed(v, $urandom_range(0, 65535), (e == len - 1), "rnd_elem");
      end
      for (int h = $urandom_range(0, 3); h > 0; h--) step("rnd_hold");
      release_result("rnd_release");
    end

    // Reset in the middle of a query, then a single-element query
    begin_query("q5_start");
    feed(1, 0, 0, "q5_e0");
    feed(2, 1, 0, "q5_e1");
    rst = 1'b1;
    feed(3, 2, 0, "q5_reset");
    rst = 1'b0;
    chk("q5_rst_cnt", b0.out_cnt, 0);
    chk("q5_rst_data", b2.out_data, 0);
    chk("q5_rst_rdy", b0.in_rdy, 0);
    begin_query("q6_start");
    feed(5, 7, 1, "q6_e0");
    chk("q6_slot0_data", b0.out_data[15:0], 5);
    chk("q6_slot0_idx", b0.out_idx[15:0], 7);
    chk("q6_cnt", b0.out_cnt, 1);
    chk("q6_vld", b0.out_vld, 1);
    release_result("q6_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
